tff_count_sequencer: RTL and testbench

- Controller that sequences an external bank of WIDTH T flip-flops (one per bit; Q fed back, T driven) as a programmable up/down modulo counter.
- Accepts commands over a valid/ready handshake: START, STOP, LOAD, CLEAR.
- Each cycle it computes the toggle vector from the current Q and its FSM state.
- Sits between the front-panel/debounced control logic and the T-FF counter datapath.

---
 rtl/tff_count_sequencer_pkg.sv | 17 +
 rtl/tff_count_sequencer_if.sv | 33 +++
 rtl/tff_toggle_gen.sv | 47 ++++
 rtl/tff_count_sequencer.sv | 137 +++++++++++++
 tb/tb_tff_count_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/tff_count_sequencer_pkg.sv
// Shared definitions for the T flip-flop count sequencer.
//   - Command opcodes carried on the cmd_op field of the command interface.
//   - 3-bit FSM state encoding, also visible on the top-level debug port.
package tff_count_sequencer_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_LOAD  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/tff_count_sequencer_if.sv
// Command channel of the T flip-flop count sequencer.
//   cmd_valid : command present (driven by master)
//   cmd_ready : sequencer can take a command this cycle (driven by slave)
//   cmd_op    : opcode, see CMD_* in tff_count_sequencer_pkg
//   cmd_data  : LOAD target value
//
// Handshake: a command transfers on every rising clk edge where
// cmd_valid && cmd_ready. cmd_ready does not depend on cmd_valid; the master
// holds cmd_op/cmd_data stable while cmd_valid is high and not yet accepted.
interface tff_count_sequencer_if #(
  parameter int WIDTH = 3
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/tff_toggle_gen.sv
// Combinational step generator for a bank of T flip-flops.
//   q        : current bank value
//   dir      : 1 = count up, 0 = count down
//   mod      : up-count terminal value / down-count reload value
//   step_t   : toggle vector that moves q one step (wrap or reload at terminal)
//   terminal : q is at the terminal value for the selected direction
module tff_toggle_gen #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic [WIDTH-1:0] mod,
  output logic [WIDTH-1:0] step_t,
  output logic             terminal
);

  logic [WIDTH-1:0] inc_t;
  logic [WIDTH-1:0] dec_t;

  // Ripple-style toggle masks: bit i toggles on increment when all lower
  // bits are ones, and on decrement when all lower bits are zeros.
  always_comb begin
    inc_t    = '0;
    dec_t    = '0;
    inc_t[0] = 1'b1;
    dec_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      inc_t[i] = inc_t[i-1] & q[i-1];
      dec_t[i] = dec_t[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    terminal = 1'b0;
    step_t   = '0;
    if (dir) begin
      // Anything at or above the terminal wraps to zero (toggle every set bit).
      terminal = (q >= mod);
      step_t   = terminal ? q : inc_t;
    end else begin
      // From zero the bank loads mod; toggling from all-zeros yields mod.
      terminal = (q == '0);
      step_t   = terminal ? mod : dec_t;
    end
  end

endmodule

// File: rtl/tff_count_sequencer.sv
// Controller that sequences an external bank of WIDTH T flip-flops as a
// programmable up/down modulo counter.
//   clk, RSTN          : clock, asynchronous active-low reset
//   cmd                : command channel (START/STOP/LOAD/CLEAR), slave side
//   dir, modulus,
//   one_shot           : run settings, sampled on an accepted START
//   tick               : count enable, one step per cycle while high in RUN
//   q                  : current Q of the T-FF bank
//   t                  : toggle vector to the bank (combinational)
//   busy / done        : in RUN / in DONE
//   tc_pulse           : high on a terminal-count step
//   state              : current FSM state (debug)
module tff_count_sequencer
  import tff_count_sequencer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  RSTN,
  tff_count_sequencer_if.slave  cmd,
  input  logic                  dir,
  input  logic [WIDTH-1:0]      modulus,
  input  logic                  one_shot,
  input  logic                  tick,
  input  logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      t,
  output logic                  busy,
  output logic                  tc_pulse,
  output logic                  done,
  output logic [2:0]            state
);

  logic [2:0]       state_r;
  logic [2:0]       next_state;
  logic             dir_r;
  logic [WIDTH-1:0] mod_r;
  logic             os_r;
  logic [WIDTH-1:0] load_r;

  logic             accept;
  logic [WIDTH-1:0] step_t;
  logic             terminal;

  // LOAD and CLEAR each own the bank for a single cycle; no command is
  // taken then so nothing can race the one-shot toggle.
  assign cmd.cmd_ready = (state_r != ST_LOAD) && (state_r != ST_CLEAR);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  assign busy  = (state_r == ST_RUN);
  assign done  = (state_r == ST_DONE);
  assign state = state_r;

  tff_toggle_gen #(.WIDTH(WIDTH)) u_toggle_gen (
    .q        (q),
    .dir      (dir_r),
    .mod      (mod_r),
    .step_t   (step_t),
    .terminal (terminal)
  );

  always_comb begin
    next_state = state_r;
    t          = '0;
    tc_pulse   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            CMD_START: next_state = ST_RUN;
            CMD_LOAD:  next_state = ST_LOAD;
            CMD_CLEAR: next_state = ST_CLEAR;
            default:   next_state = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (accept && (cmd.cmd_op != CMD_START)) begin
          // STOP/LOAD/CLEAR pre-empt the count step this cycle.
          case (cmd.cmd_op)
            CMD_LOAD:  next_state = ST_LOAD;
            CMD_CLEAR: next_state = ST_CLEAR;
            default:   next_state = ST_IDLE;
          endcase
        end else if (tick) begin
          // A START here only refreshes the latched settings; this step
          // still uses the previous ones.
          tc_pulse = terminal;
          if (terminal && os_r && !accept) begin
            next_state = ST_DONE;
          end else if (!(terminal && os_r)) begin
            t = step_t;
          end
        end
      end
      ST_LOAD: begin
        t          = q ^ load_r;
        next_state = ST_IDLE;
      end
      ST_CLEAR: begin
        t          = q;
        next_state = ST_IDLE;
      end
      ST_DONE: begin
        if (accept) begin
          case (cmd.cmd_op)
            CMD_START: next_state = ST_RUN;
            CMD_LOAD:  next_state = ST_LOAD;
            CMD_CLEAR: next_state = ST_CLEAR;
            default:   next_state = ST_IDLE;
          endcase
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= ST_IDLE;
      dir_r   <= 1'b1;
      mod_r   <= '1;
      os_r    <= 1'b0;
      load_r  <= '0;
    end else begin
      state_r <= next_state;
      if (accept && (cmd.cmd_op == CMD_START)) begin
        dir_r <= dir;
        mod_r <= modulus;
        os_r  <= one_shot;
      end
      if (accept && (cmd.cmd_op == CMD_LOAD)) begin
        load_r <= cmd.cmd_data;
      end
    end
  end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Bench for tff_count_sequencer driving an external T flip-flop bank.
module tb_tff_count_sequencer;
  import tff_count_sequencer_pkg::*;

  localparam int W  = 3;
  localparam int EW = 3 * W + 4;

  logic         clk;
  logic         RSTN;
  logic         dir;
  logic         one_shot;
  logic         tick;
  logic [W-1:0] modulus;
  logic [W-1:0] q;
  logic [W-1:0] t;
  logic         busy;
  logic         tc_pulse;
  logic         done;
  logic [2:0]   state;

  tff_count_sequencer_if #(.WIDTH(W)) cmd_if ();

  tff_count_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .RSTN     (RSTN),
    .cmd      (cmd_if.slave),
    .dir      (dir),
    .modulus  (modulus),
    .one_shot (one_shot),
    .tick     (tick),
    .q        (q),
    .t        (t),
    .busy     (busy),
    .tc_pulse (tc_pulse),
    .done     (done),
    .state    (state)
  );

  // T flip-flop bank, reset by the same RSTN.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) q <= '0;
    else       q <= q ^ t;
  end

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks;
  int            errors;

  task automatic push_exp(input string nm, input logic [2:0] eq, input logic [2:0] et,
                          input logic etc, input logic [2:0] est);
    logic eb, ed, er;
    eb = (est == ST_RUN);
    ed = (est == ST_DONE);
    er = (est != ST_LOAD) && (est != ST_CLEAR);
    exp_q.push_back({eq, et, etc, eb, ed, er, est});
    name_q.push_back(nm);
  endtask

  // Monitor: samples mid low phase, after inputs have settled.
  initial begin : monitor
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    string         nm;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {q, t, tc_pulse, busy, done, cmd_if.cmd_ready, state};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s got q=%0d t=%0d tc=%0b busy=%0b done=%0b rdy=%0b st=%0d expected q=%0d t=%0d tc=%0b busy=%0b done=%0b rdy=%0b st=%0d",
                   nm, a[12:10], a[9:7], a[6], a[5], a[4], a[3], a[2:0],
                   e[12:10], e[9:7], e[6], e[5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_cycle(input string nm, input logic tk, input logic [2:0] eq,
                            input logic [2:0] et, input logic etc, input logic [2:0] est);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    tick             = tk;
    push_exp(nm, eq, et, etc, est);
  endtask

  task automatic cmd_cycle(input string nm, input logic [1:0] op, input logic [2:0] data,
                           input logic d, input logic [2:0] m, input logic os, input logic tk,
                           input logic [2:0] eq, input logic [2:0] et, input logic etc,
                           input logic [2:0] est);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    dir              = d;
    modulus          = m;
    one_shot         = os;
    tick             = tk;
    push_exp(nm, eq, et, etc, est);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] up5_q [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
  logic [2:0] up5_t [8] = '{3'd1, 3'd3, 3'd1, 3'd7, 3'd1, 3'd5, 3'd1, 3'd3};
  logic [2:0] dn6_q [8] = '{3'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  logic [2:0] dn6_t [8] = '{3'd6, 3'd3, 3'd1, 3'd7, 3'd1, 3'd3, 3'd1, 3'd6};
  logic [2:0] up7_t [7] = '{3'd1, 3'd3, 3'd1, 3'd7, 3'd1, 3'd3, 3'd1};
  logic [2:0] dn2_q [7] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd2};
  logic [2:0] dn2_t [7] = '{3'd1, 3'd7, 3'd1, 3'd3, 3'd1, 3'd2, 3'd3};

  initial begin : stimulus
    checks           = 0;
    errors           = 0;
    RSTN             = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = CMD_STOP;
    cmd_if.cmd_data  = 3'd0;
    dir              = 1'b1;
    modulus          = 3'd0;
    one_shot         = 1'b0;
    tick             = 1'b0;

    @(negedge clk);
    RSTN = 1'b1;
    push_exp("reset", 3'd0, 3'd0, 1'b0, ST_IDLE);

    // 1: up count modulo 5
    cmd_cycle("t1_start", CMD_START, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, ST_IDLE);
    for (int i = 0; i < 8; i++)
      tick_cycle($sformatf("t1_up%0d", i), 1'b1, up5_q[i], up5_t[i], (i == 5), ST_RUN);

    // 2: down count reload 6, then alternating tick
    cmd_cycle("t2_stop", CMD_STOP, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, ST_RUN);
    cmd_cycle("t2_clear_cmd", CMD_CLEAR, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, ST_IDLE);
    tick_cycle("t2_clear_st", 1'b0, 3'd2, 3'd2, 1'b0, ST_CLEAR);
    cmd_cycle("t2_start", CMD_START, 3'd0, 1'b0, 3'd6, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, ST_IDLE);
    for (int i = 0; i < 8; i++)
      tick_cycle($sformatf("t2_dn%0d", i), 1'b1, dn6_q[i], dn6_t[i], (i == 0 || i == 7), ST_RUN);
    tick_cycle("t2_alt0", 1'b0, 3'd6, 3'd0, 1'b0, ST_RUN);
    tick_cycle("t2_alt1", 1'b1, 3'd6, 3'd3, 1'b0, ST_RUN);
    tick_cycle("t2_alt2", 1'b0, 3'd5, 3'd0, 1'b0, ST_RUN);
    tick_cycle("t2_alt3", 1'b1, 3'd5, 3'd1, 1'b0, ST_RUN);

    // 3: LOAD 101 from 010, then CLEAR
    cmd_cycle("t3_stop", CMD_STOP, 3'd0, 1'b0, 3'd6, 1'b0, 1'b1, 3'd4, 3'd0, 1'b0, ST_RUN);
    cmd_cycle("t3_load2_cmd", CMD_LOAD, 3'd2, 1'b0, 3'd6, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, ST_IDLE);
    tick_cycle("t3_load2_st", 1'b0, 3'd4, 3'd6, 1'b0, ST_LOAD);
    cmd_cycle("t3_load5_cmd", CMD_LOAD, 3'd5, 1'b0, 3'd6, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, ST_IDLE);
    tick_cycle("t3_load5_st", 1'b0, 3'd2, 3'd7, 1'b0, ST_LOAD);
    tick_cycle("t3_loaded", 1'b0, 3'd5, 3'd0, 1'b0, ST_IDLE);
    cmd_cycle("t3_clear_cmd", CMD_CLEAR, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0, 3'd5, 3'd0, 1'b0, ST_IDLE);
    tick_cycle("t3_clear_st", 1'b0, 3'd5, 3'd5, 1'b0, ST_CLEAR);
    tick_cycle("t3_cleared", 1'b0, 3'd0, 3'd0, 1'b0, ST_IDLE);

    // 4: one-shot up to 7, then restart from DONE
    cmd_cycle("t4_start", CMD_START, 3'd0, 1'b1, 3'd7, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, ST_IDLE);
    for (int i = 0; i < 7; i++)
      tick_cycle($sformatf("t4_up%0d", i), 1'b1, 3'(i), up7_t[i], 1'b0, ST_RUN);
    tick_cycle("t4_term", 1'b1, 3'd7, 3'd0, 1'b1, ST_RUN);
    tick_cycle("t4_done", 1'b1, 3'd7, 3'd0, 1'b0, ST_DONE);
    cmd_cycle("t4_restart", CMD_START, 3'd0, 1'b1, 3'd7, 1'b0, 1'b1, 3'd7, 3'd0, 1'b0, ST_DONE);
    tick_cycle("t4_wrap", 1'b1, 3'd7, 3'd7, 1'b1, ST_RUN);
    tick_cycle("t4_after", 1'b1, 3'd0, 3'd1, 1'b0, ST_RUN);

    // 5: STOP at q=4; LOAD wins over a ticked step at q=2
    tick_cycle("t5_q1", 1'b1, 3'd1, 3'd3, 1'b0, ST_RUN);
    tick_cycle("t5_q2", 1'b1, 3'd2, 3'd1, 1'b0, ST_RUN);
    tick_cycle("t5_q3", 1'b1, 3'd3, 3'd7, 1'b0, ST_RUN);
    cmd_cycle("t5_stop", CMD_STOP, 3'd0, 1'b1, 3'd7, 1'b0, 1'b1, 3'd4, 3'd0, 1'b0, ST_RUN);
    tick_cycle("t5_idle", 1'b1, 3'd4, 3'd0, 1'b0, ST_IDLE);
    cmd_cycle("t5_clear_cmd", CMD_CLEAR, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, ST_IDLE);
    tick_cycle("t5_clear_st", 1'b0, 3'd4, 3'd4, 1'b0, ST_CLEAR);
    cmd_cycle("t5_start", CMD_START, 3'd0, 1'b1, 3'd7, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, ST_IDLE);
    tick_cycle("t5_r0", 1'b1, 3'd0, 3'd1, 1'b0, ST_RUN);
    tick_cycle("t5_r1", 1'b1, 3'd1, 3'd3, 1'b0, ST_RUN);
    cmd_cycle("t5_load_run", CMD_LOAD, 3'd6, 1'b1, 3'd7, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, ST_RUN);
    tick_cycle("t5_load_st", 1'b1, 3'd2, 3'd4, 1'b0, ST_LOAD);
    tick_cycle("t5_loaded", 1'b0, 3'd6, 3'd0, 1'b0, ST_IDLE);

    // 6: asynchronous reset mid-RUN at a terminal step, then modulus 0
    cmd_cycle("t6_start", CMD_START, 3'd0, 1'b1, 3'd7, 1'b0, 1'b1, 3'd6, 3'd0, 1'b0, ST_IDLE);
    tick_cycle("t6_q6", 1'b1, 3'd6, 3'd1, 1'b0, ST_RUN);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    tick             = 1'b1;
    #1 RSTN = 1'b0;
    push_exp("t6_async_rst", 3'd0, 3'd0, 1'b0, ST_IDLE);
    @(negedge clk);
    RSTN = 1'b1;
    push_exp("t6_post_rst", 3'd0, 3'd0, 1'b0, ST_IDLE);
    cmd_cycle("t6_start_m0", CMD_START, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, ST_IDLE);
    for (int i = 0; i < 3; i++)
      tick_cycle($sformatf("t6_m0_up%0d", i), 1'b1, 3'd0, 3'd0, 1'b1, ST_RUN);
    cmd_cycle("t6_restart_dn", CMD_START, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, ST_RUN);
    for (int i = 0; i < 2; i++)
      tick_cycle($sformatf("t6_m0_dn%0d", i), 1'b1, 3'd0, 3'd0, 1'b1, ST_RUN);

    // 7: down count from above the modulus
    cmd_cycle("t7_stop", CMD_STOP, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, ST_RUN);
    cmd_cycle("t7_load_cmd", CMD_LOAD, 3'd5, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, ST_IDLE);
    tick_cycle("t7_load_st", 1'b0, 3'd0, 3'd5, 1'b0, ST_LOAD);
    cmd_cycle("t7_start", CMD_START, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1, 3'd5, 3'd0, 1'b0, ST_IDLE);
    for (int i = 0; i < 7; i++)
      tick_cycle($sformatf("t7_dn%0d", i), 1'b1, dn2_q[i], dn2_t[i], (i == 5), ST_RUN);

    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    tick             = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
